// File: rtl/pwm_peripheral_pkg.sv
// Shared constants for the PWM peripheral and the SPI register block that feeds it.
package pwm_peripheral_pkg;

  localparam int unsigned PWM_W           = 8;
  localparam int unsigned NUM_PINS        = 16;
  localparam logic [7:0]  DUTY_FULL       = 8'hFF;
  localparam int unsigned CLK_DIV_DEFAULT = 13;

  // Register map shared with the SPI block.
  typedef enum logic [7:0] {
    RegEnOut70  = 8'h00,
    RegEnOut158 = 8'h01,
    RegEnPwm70  = 8'h02,
    RegEnPwm158 = 8'h03,
    RegPwmDuty  = 8'h04
  } reg_addr_e;

  // Output enable wins over PWM mode; enabled non-PWM pins are static high.
  function automatic logic pin_level(input logic en_out, input logic en_pwm, input logic pwm_hi);
    return en_out & (~en_pwm | pwm_hi);
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register levels from the SPI block into the PWM peripheral, plus the pin drive coming back.
interface pwm_peripheral_if;
  import pwm_peripheral_pkg::*;

  logic [7:0]          en_reg_out_7_0;
  logic [7:0]          en_reg_out_15_8;
  logic [7:0]          en_reg_pwm_7_0;
  logic [7:0]          en_reg_pwm_15_8;
  logic [PWM_W-1:0]    pwm_duty_cycle;
  logic [NUM_PINS-1:0] out;
  logic                period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_peripheral_timebase.sv
// Shared PWM timebase: prescaler, 8-bit period counter, double-buffered duty and
// the period boundary pulse.
module pwm_timebase
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] pwm_duty_cycle,
  output logic             pwm_hi,
  output logic             period_start
);

  localparam int unsigned     DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             period_start_q, period_start_d;
  logic             tick;
  logic             boundary;

  always_comb begin
    tick           = (div_cnt_q == DivMax);
    div_cnt_d      = tick ? '0 : div_cnt_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    // Duty is only picked up as the counter wraps, so a period never changes shape midway.
    boundary       = tick && (pwm_cnt_q == {PWM_W{1'b1}});
    duty_d         = boundary ? pwm_duty_cycle : duty_q;
    period_start_d = boundary;
    pwm_hi         = (duty_q == DUTY_FULL) || (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin is off, static high or the shared PWM waveform,
// registered once per clk.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_peripheral_if.slave   bus
);

  logic [NUM_PINS-1:0] en_out;
  logic [NUM_PINS-1:0] en_pwm;
  logic [NUM_PINS-1:0] out_d, out_q;
  logic                pwm_hi;
  logic                period_start;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_duty_cycle (bus.pwm_duty_cycle),
    .pwm_hi         (pwm_hi),
    .period_start   (period_start)
  );

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      out_d[i] = pin_level(en_out[i], en_pwm[i], pwm_hi);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start;

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register block. Takes the five SPI-written control registers and drives 16 output pins.
- Each pin is one of: off, static high, or a shared 8-bit PWM waveform at about 3 kHz (10 MHz clk).
- The duty value is double-buffered so a duty change never glitches the waveform mid-period.

Parameters:
- CLK_DIV, 13, clk cycles per PWM counter tick. Must be >= 1. PWM period = 256*CLK_DIV clk cycles (3328 at the default, 3004.8 Hz at 10 MHz).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- en_reg_out_7_0  input  8  output enable, pins 7:0
- en_reg_out_15_8  input  8  output enable, pins 15:8
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7:0
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15:8
- pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%
- out  output  16  pin drive; bit i = pin i
- period_start  output  1  one-clk pulse at each PWM period boundary
- Interface decision: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset (asserted at any time, including mid-period) immediately clears all state: div_cnt=0, pwm_cnt=0, duty_active=0x00, out=16'h0000, period_start=0.
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1.
  - When div_cnt==CLK_DIV-1: div_cnt<=0 and tick=1 for that cycle. Otherwise div_cnt increments.
  - CLK_DIV=1 gives tick every cycle.
- Period counter:
  - On tick, pwm_cnt<=pwm_cnt+1, 8-bit, wrapping 255->0.
  - No change on cycles without a tick.
- Duty shadow:
  - On tick with pwm_cnt==255: duty_active<=pwm_duty_cycle and period_start<=1 (registered).
  - period_start is 0 on every other cycle.
  - pwm_duty_cycle changes at any other time have no effect until the next boundary.
  - After reset the first period runs with duty_active=0. The first load happens 256*CLK_DIV cycles after reset release.
- PWM level:
  - pwm_hi = (duty_active==8'hFF) | (pwm_cnt < duty_active).
  - Duty d < 255 gives d*CLK_DIV high cycles per period. 255 gives constant high. 0 gives constant low.
- Per-pin select, evaluated combinationally and registered into out every clk (en_out = {en_reg_out_15_8, en_reg_out_7_0}, en_pwm likewise):
  - en_out[i]==0 -> 0. Output enable takes priority over PWM mode.
  - en_out[i]==1, en_pwm[i]==0 -> 1.
  - en_out[i]==1, en_pwm[i]==1 -> pwm_hi.
- Latency:
  - Enable/mode input change -> out reflects it on the next rising clk edge (1 cycle).
  - out lags pwm_cnt/duty_active by 1 clk.
- Enable inputs are sampled every cycle, not shadowed. A mode change mid-period takes effect immediately with the current counter phase.
- All PWM pins share one counter and are phase-aligned.
- No handshake with upstream: the register inputs are static levels owned by the SPI block, in the same clk domain, so no synchronisers are needed.

Decomposition:
- Shared package holds:
  - PWM_W=8
  - NUM_PINS=16
  - DUTY_FULL=8'hFF
  - default CLK_DIV=13
  - register address constants 0x00-0x04 (also used by the SPI block)
- One natural sub-module, pwm_timebase: prescaler, pwm_cnt, duty shadow and period_start. Outputs pwm_hi and period_start.
- pwm_peripheral instantiates pwm_timebase and holds the 16-bit select/output register.

Test Plan:
- Reset mid-operation: run with en_out=en_pwm=0xFFFF, duty=0x80, assert rst_n=0 at pwm_cnt≈100 -> out=0x0000, period_start=0 immediately (async). After release, pwm_cnt restarts at 0 and the first period is all low.
- Static outputs: en_out=0x00FF, en_pwm=0x0000 -> out=0x00FF exactly 1 clk later. Then set en_pwm=0xFF00 with en_out unchanged -> out stays 0x00FF.
- 50% duty: CLK_DIV=13, en_out=en_pwm=0x0001, duty=0x80 -> from the second period onward out[0] is high 1664 clk and low 1664 clk, period 3328. period_start pulses every 3328 clk, coincident with the rising edge of out[0] one clk earlier.
- Extremes: duty=0x00 -> out[0] constantly 0 across full periods. duty=0xFF -> out[0] constantly 1 with no low cycle across period boundaries.
- Mid-period duty change: duty=0x40 settled, write 0xC0 at pwm_cnt=10 -> current period high 832 clk, next period high 2496 clk, no runt pulse.
- CLK_DIV=1 build: duty=0x03 -> out high 3 clk, low 253 clk, period 256 clk. period_start every 256 clk.
